// File: rtl/tick_counter_pkg.sv
// ---------------------------------------------------------------------------
// tick_counter_pkg
// Shared elaboration-time helpers for the tick-paced up/down counter:
//   clog2()      - ceiling log2, used to size the prescaler
//   calc_div()   - clock cycles per tick (integer division)
//   params_ok()  - parameter legality: DIV >= 2 and C_MAX fits in WIDTH bits
// ---------------------------------------------------------------------------
package tick_counter_pkg;

  // Ceiling log2; clog2(1) = 0. Only called with DIV >= 2, so the result
  // is always at least 1.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  function automatic int calc_div(input int clk_freq_hz, input int tick_freq_hz);
    return clk_freq_hz / tick_freq_hz;
  endfunction

  // True when the parameter set describes a buildable counter.
  function automatic bit params_ok(input int clk_freq_hz, input int tick_freq_hz,
                                   input int width, input int c_max);
    bit ok;
    ok = (tick_freq_hz > 0) && (calc_div(clk_freq_hz, tick_freq_hz) >= 2);
    ok = ok && (width >= 1) && (c_max >= 0);
    if (width < 31) begin
      ok = ok && (c_max < (1 << width));
    end
    return ok;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Free-running prescaler that emits a one-cycle enable pulse once every
// DIV = CLK_FREQ_HZ / TICK_FREQ_HZ cycles of clk.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset, restarts the prescaler at 0
//   tick - one-cycle pulse while the prescaler sits at DIV-1 (never in reset)
// ---------------------------------------------------------------------------
module tick_gen
  import tick_counter_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int TICK_FREQ_HZ = 5
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            DIV     = calc_div(CLK_FREQ_HZ, TICK_FREQ_HZ);
  localparam int            PW      = clog2(DIV);
  localparam logic [PW-1:0] LP_LAST = PW'(DIV - 1);

  logic [PW-1:0] r_prescaler;
  logic          w_last;

  assign w_last = (r_prescaler == LP_LAST);

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would create order races.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prescaler <= '0;
    end else if (w_last) begin
      r_prescaler <= '0;
    end else begin
      r_prescaler <= r_prescaler + PW'(1);
    end
  end

  // Masked by rst: tick stays low throughout reset, even if the prescaler
  // happened to be at its last value.
  assign tick = w_last && !rst;

endmodule

// File: rtl/tick_updown_counter.sv
// ---------------------------------------------------------------------------
// tick_updown_counter
// Up/down counter over 0..C_MAX stepped by an internal tick, single clock
// domain. Supports wrap or saturate at the range ends, synchronous clamped
// load, a terminal-count pulse and a tick-rate LED square wave.
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous active-high reset
//   enable    - gates counting only; the prescaler keeps running
//   up_down   - 1 = up, 0 = down (sampled on tick cycles)
//   wrap_mode - 1 = wrap at range ends, 0 = saturate
//   load      - synchronous load strobe, beats a simultaneous tick
//   load_val  - load value, clamped to C_MAX
//   count     - current count
//   tick      - one-cycle pulse every DIV cycles
//   term      - tick cycle where the count sits at the boundary for the
//               current direction (combinational)
//   led_clk   - toggles on every tick, period 2*DIV
// ---------------------------------------------------------------------------
module tick_updown_counter
  import tick_counter_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int TICK_FREQ_HZ = 5,
  parameter int WIDTH        = 8,
  parameter int C_MAX        = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             up_down,
  input  logic             wrap_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             term,
  output logic             led_clk
);

  if (!params_ok(CLK_FREQ_HZ, TICK_FREQ_HZ, WIDTH, C_MAX)) begin : g_bad_params
    $error("tick_updown_counter: need DIV >= 2 and C_MAX < 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] LP_CMAX = WIDTH'(C_MAX);

  logic             w_tick;
  logic             w_at_top;
  logic             w_at_bottom;
  logic             w_at_bound;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] r_count;
  logic             r_led_clk;

  tick_gen #(
    .CLK_FREQ_HZ  (CLK_FREQ_HZ),
    .TICK_FREQ_HZ (TICK_FREQ_HZ)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  assign w_at_top    = (r_count == LP_CMAX);
  assign w_at_bottom = (r_count == '0);
  assign w_at_bound  = up_down ? w_at_top : w_at_bottom;

  // Next value if this tick steps the counter. At a range end the count
  // either jumps to the opposite end (wrap) or stays put (saturate).
  // NOTE: w_step gets its default before any branch, so every path assigns
  // it and no latch can be inferred.
  always_comb begin
    w_step = r_count;
    if (up_down) begin
      if (!w_at_top) begin
        w_step = r_count + WIDTH'(1);
      end else if (wrap_mode) begin
        w_step = '0;
      end
    end else begin
      if (!w_at_bottom) begin
        w_step = r_count - WIDTH'(1);
      end else if (wrap_mode) begin
        w_step = LP_CMAX;
      end
    end
  end

  // Loads above the range are clamped so count never leaves 0..C_MAX.
  assign w_load_clamped = (load_val > LP_CMAX) ? LP_CMAX : load_val;

  // Load has priority: a tick arriving with load is consumed without a step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= w_load_clamped;
    end else if (w_tick && enable) begin
      r_count <= w_step;
    end
  end

  // Independent of enable so the LED keeps showing the tick rate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_led_clk <= 1'b0;
    end else if (w_tick) begin
      r_led_clk <= ~r_led_clk;
    end
  end

  // Fires while saturated too: the boundary is reached regardless of mode.
  assign term    = w_tick && enable && !load && w_at_bound;
  assign count   = r_count;
  assign tick    = w_tick;
  assign led_clk = r_led_clk;

endmodule

// File: tb/tb_tick_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_tick_updown_counter
// Bench for tick_updown_counter with DIV = 10, WIDTH = 4, C_MAX = 5.
// Inputs change on the falling edge; outputs are read shortly after it.
// ---------------------------------------------------------------------------
module tb_tick_updown_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         up_down;
  logic         wrap_mode;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         tick;
  logic         term;
  logic         led_clk;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tick_updown_counter #(
    .CLK_FREQ_HZ  (10),
    .TICK_FREQ_HZ (1),
    .WIDTH        (W),
    .C_MAX        (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .up_down   (up_down),
    .wrap_mode (wrap_mode),
    .load      (load),
    .load_val  (load_val),
    .count     (count),
    .tick      (tick),
    .term      (term),
    .led_clk   (led_clk)
  );

  typedef struct {
    logic up_down;
    logic wrap_mode;
    int   exp_count;
    logic exp_term;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Advance falling edge by falling edge until a tick cycle; n is the number
  // of edges advanced. Bounded so a dead prescaler cannot hang the run.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 40);
    if (!tick) begin
      check("tick_timeout", 32'd0, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    int toggles;
    int bad;
    int tick_idx;
    logic prev_led;

    // up/wrap: 1,2,3,4,5,0 with term on count 5
    vecs.push_back('{1'b1, 1'b1, 0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 2, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 3, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 4, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 5, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 0, 1'b0});
    // up/saturate: hold at 5, term on every tick there
    vecs.push_back('{1'b1, 1'b0, 1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 2, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 3, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 4, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 5, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 5, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 5, 1'b1});
    // down/wrap: 4..0 then 0 -> 5
    vecs.push_back('{1'b0, 1'b1, 5, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 3, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 2, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 5, 1'b0});
    // down/saturate: hold at 0
    vecs.push_back('{1'b0, 1'b0, 4, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 3, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 0, 1'b1});

    // ---- reset ------------------------------------------------------------
    rst       = 1'b1;
    enable    = 1'b0;
    up_down   = 1'b1;
    wrap_mode = 1'b1;
    load      = 1'b0;
    load_val  = '0;
    seen      = 0;
    repeat (12) begin
      @(negedge clk);
      if (tick) seen++;
    end
    check("reset_count", 32'(count), 32'd0);
    check("reset_led", 32'(led_clk), 32'd0);
    check("reset_term", 32'(term), 32'd0);
    check("reset_no_tick", 32'(seen), 32'd0);

    // ---- release: first tick in the 10th cycle ----------------------------
    enable = 1'b1;
    rst    = 1'b0;
    wait_tick(n);
    check("first_tick_cycle", 32'(n + 1), 32'd10);

    // ---- table: one entry per tick cycle ----------------------------------
    tick_idx = 0;
    foreach (vecs[i]) begin
      up_down   = vecs[i].up_down;
      wrap_mode = vecs[i].wrap_mode;
      #1;
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_term", i), 32'(term), 32'(vecs[i].exp_term));
      check($sformatf("vec%0d_led", i), 32'(led_clk), 32'(tick_idx % 2));
      wait_tick(n);
      check($sformatf("vec%0d_period", i), 32'(n), 32'd10);
      tick_idx++;
    end

    // ---- load on a tick cycle (count = 0, down: term would fire) ----------
    load      = 1'b1;
    load_val  = 4'd3;
    up_down   = 1'b0;
    wrap_mode = 1'b1;
    #1;
    check("load_tick_term", 32'(term), 32'd0);
    @(negedge clk);
    check("load_no_step", 32'(count), 32'd3);
    // clamped load with enable low
    enable   = 1'b0;
    load_val = 4'd12;
    @(negedge clk);
    check("load_clamp_disabled", 32'(count), 32'd5);
    load = 1'b0;

    // ---- enable low for 30 cycles -----------------------------------------
    seen     = 0;
    toggles  = 0;
    bad      = 0;
    prev_led = led_clk;
    repeat (30) begin
      @(negedge clk);
      if (tick) seen++;
      if (led_clk !== prev_led) toggles++;
      prev_led = led_clk;
      if (count !== 4'd5) bad++;
    end
    check("freeze_count_changes", 32'(bad), 32'd0);
    check("freeze_ticks", 32'(seen), 32'd3);
    check("freeze_led_toggles", 32'(toggles), 32'd3);

    // ---- reset at prescaler = 6 with led_clk high -------------------------
    for (int k = 0; k < 3; k++) begin
      wait_tick(n);
      @(negedge clk);
      if (led_clk === 1'b1) break;
    end
    check("pre_reset_led", 32'(led_clk), 32'd1);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset_count", 32'(count), 32'd0);
    check("midreset_led", 32'(led_clk), 32'd0);
    wait_tick(n);
    check("midreset_next_tick", 32'(n + 1), 32'd10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
